// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus controller and the
// datagen load-extend stage that consumes its right-aligned load data.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } lsu_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // datagen extend-select codes; decode drives both blocks from these
   localparam logic [2:0] DG_LB  = 3'b000;
   localparam logic [2:0] DG_LH  = 3'b001;
   localparam logic [2:0] DG_LW  = 3'b010;
   localparam logic [2:0] DG_LBU = 3'b011;
   localparam logic [2:0] DG_LHU = 3'b100;

   // size 2'b11 is reserved and behaves as a word access
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if (size == SZ_HALF) begin
         mis = addr_lo[0];
      end else if (size >= SZ_WORD) begin
         mis = (addr_lo != 2'b00);
      end
      return mis;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store-side replication and byte enables from the
// incoming request, load-side right shift from the latched access.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_st_size,
   input  logic [1:0]  i_st_addr_lo,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_st_wdata,
   output logic [3:0]  o_st_be,
   input  logic [1:0]  i_ld_size,
   input  logic [1:0]  i_ld_addr_lo,
   input  logic [31:0] i_ld_rdata,
   output logic [31:0] o_ld_data
);

   // replicate store data into every lane so the enabled lane always carries it
   always_comb begin
      o_st_wdata = i_st_data;
      o_st_be    = 4'b1111;
      case (i_st_size)
         SZ_BYTE: begin
            o_st_wdata = {4{i_st_data[7:0]}};
            o_st_be    = 4'b0001 << i_st_addr_lo;
         end
         SZ_HALF: begin
            o_st_wdata = {2{i_st_data[15:0]}};
            o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // upper bits stay as shifted (not masked); datagen does the extension
   always_comb begin
      o_ld_data = i_ld_rdata;
      if ((i_ld_size == SZ_BYTE) || (i_ld_size == SZ_HALF)) begin
         o_ld_data = i_ld_rdata >> {i_ld_addr_lo, 3'b000};
      end
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: runs one req/ack data-memory transaction per
// aligned core request, stalling the core until it completes or times out.
//
// state | meaning
// IDLE  | waiting for an aligned load/store; accepts and stalls in same cycle
// REQ   | o_bus_req high, waiting for i_bus_ack or timeout
// DONE  | one-cycle o_done pulse, core advances, back to IDLE
module lsu_bus_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_lsu_re,
   input  logic        i_lsu_we,
   input  logic [1:0]  i_lsu_size,
   input  logic [31:0] i_lsu_addr,
   input  logic [31:0] i_lsu_wdata,
   output logic        o_stall,
   output logic [31:0] o_ld_data,
   output logic        o_done,
   output logic        o_misalign,
   output logic        o_bus_err,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_be,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_e  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] ld_data_q, ld_data_d;
   logic        done_q, done_d;
   logic        bus_err_q, bus_err_d;

   logic        req_any;
   logic        misalign;
   logic        accept;
   logic [31:0] st_wdata;
   logic [3:0]  st_be;
   logic [31:0] ld_shifted;

   lsu_lane_align u_lane_align (
      .i_st_size    (i_lsu_size),
      .i_st_addr_lo (i_lsu_addr[1:0]),
      .i_st_data    (i_lsu_wdata),
      .o_st_wdata   (st_wdata),
      .o_st_be      (st_be),
      .i_ld_size    (size_q),
      .i_ld_addr_lo (addr_lo_q),
      .i_ld_rdata   (i_bus_rdata),
      .o_ld_data    (ld_shifted)
   );

   assign req_any  = i_lsu_re | i_lsu_we;
   assign misalign = req_any & is_misaligned(i_lsu_size, i_lsu_addr[1:0]);
   assign accept   = (state_q == IDLE) & req_any & ~misalign;

   // next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      addr_lo_d   = addr_lo_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      ld_data_d   = ld_data_q;
      done_d      = 1'b0;
      bus_err_d   = bus_err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = REQ;
               cnt_d       = 8'd0;
               size_d      = i_lsu_size;
               addr_lo_d   = i_lsu_addr[1:0];
               bus_req_d   = 1'b1;
               // re and we together resolve as a store
               bus_we_d    = i_lsu_we;
               bus_addr_d  = {i_lsu_addr[31:2], 2'b00};
               bus_wdata_d = st_wdata;
               bus_be_d    = i_lsu_we ? st_be : 4'b0000;
            end
         end
         REQ: begin
            // ack wins over a timeout landing in the same cycle
            if (i_bus_ack) begin
               state_d   = DONE;
               bus_req_d = 1'b0;
               done_d    = 1'b1;
               bus_err_d = 1'b0;
               if (!bus_we_q) begin
                  ld_data_d = ld_shifted;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d   = DONE;
               bus_req_d = 1'b0;
               done_d    = 1'b1;
               bus_err_d = 1'b1;
               ld_data_d = 32'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            state_d   = IDLE;
            cnt_d     = 8'd0;
            bus_err_d = 1'b0;
         end
         default: begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
            cnt_d     = 8'd0;
         end
      endcase
   end

   // state and output registers; reset aborts any transaction in flight
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         size_q      <= 2'b00;
         addr_lo_q   <= 2'b00;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         bus_be_q    <= 4'b0000;
         ld_data_q   <= 32'd0;
         done_q      <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         addr_lo_q   <= addr_lo_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         ld_data_q   <= ld_data_d;
         done_q      <= done_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign o_stall     = accept | (state_q == REQ);
   assign o_misalign  = misalign;
   assign o_bus_req   = bus_req_q;
   assign o_bus_we    = bus_we_q;
   assign o_bus_addr  = bus_addr_q;
   assign o_bus_wdata = bus_wdata_q;
   assign o_bus_be    = bus_be_q;
   assign o_ld_data   = ld_data_q;
   assign o_done      = done_q;
   assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed scenarios plus randomized aligned
// accesses checked against a transaction-level reference model.
module tb_lsu_bus_ctrl;
   import lsu_pkg::*;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        re, we, ack;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata;
   logic        o_stall, o_done, o_misalign, o_bus_err, o_bus_req, o_bus_we;
   logic [31:0] o_ld_data, o_bus_addr, o_bus_wdata;
   logic [3:0]  o_bus_be;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] model_ld = 32'd0;

   always #5 clk = ~clk;

   lsu_bus_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_lsu_re    (re),
      .i_lsu_we    (we),
      .i_lsu_size  (size),
      .i_lsu_addr  (addr),
      .i_lsu_wdata (wdata),
      .o_stall     (o_stall),
      .o_ld_data   (o_ld_data),
      .o_done      (o_done),
      .o_misalign  (o_misalign),
      .o_bus_err   (o_bus_err),
      .o_bus_req   (o_bus_req),
      .o_bus_we    (o_bus_we),
      .o_bus_addr  (o_bus_addr),
      .o_bus_wdata (o_bus_wdata),
      .o_bus_be    (o_bus_be),
      .i_bus_ack   (ack),
      .i_bus_rdata (rdata)
   );

   // downstream datagen extension, used to confirm the load data is ready for it
   function automatic logic [31:0] dg_extend(input logic [2:0] sel, input logic [31:0] d);
      case (sel)
         DG_LB:   return {{24{d[7]}}, d[7:0]};
         DG_LH:   return {{16{d[15]}}, d[15:0]};
         DG_LBU:  return {24'd0, d[7:0]};
         DG_LHU:  return {16'd0, d[15:0]};
         DG_LW:   return d;
         default: return d;
      endcase
   endfunction

   // one complete access; ack_dly = REQ cycles before ack (>= T means never)
   task automatic run_access(input string nm, input logic r, input logic w,
                             input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int ack_dly);
      logic [31:0] e_wd, e_ld, e_addr;
      logic [3:0]  e_be;
      logic        st, to;
      int          nreq;
      st     = w;
      e_addr = a & 32'hFFFF_FFFC;
      if (sz == 2'd0) begin
         e_wd = 32'(wd[7:0]) * 32'h0101_0101;
         e_be = 4'(1 << a[1:0]);
      end else if (sz == 2'd1) begin
         e_wd = 32'(wd[15:0]) * 32'h0001_0001;
         e_be = 4'(3 << (2 * a[1]));
      end else begin
         e_wd = wd;
         e_be = 4'hF;
      end
      if (!st) e_be = 4'h0;
      to   = (ack_dly >= T);
      nreq = to ? T : ack_dly + 1;
      if (to)       e_ld = 32'd0;
      else if (st)  e_ld = model_ld;
      else if (sz < 2) e_ld = rd >> (8 * a[1:0]);
      else          e_ld = rd;

      @(posedge clk); #1;
      re = r; we = w; size = sz; addr = a; wdata = wd; ack = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({o_stall, o_bus_req, o_done, o_misalign} !== 4'b1000) begin
         n_fail++;
         $display("FAIL %s accept: stall/req/done/mis=%b%b%b%b expected 1000",
                  nm, o_stall, o_bus_req, o_done, o_misalign);
      end
      for (int k = 0; k < nreq; k++) begin
         @(posedge clk); #1;
         ack   = (k == ack_dly);
         rdata = (k == ack_dly) ? rd : $urandom;
         @(negedge clk);
         n_tests++;
         if ({o_bus_req, o_stall, o_done} !== 3'b110) begin
            n_fail++;
            $display("FAIL %s req%0d: req/stall/done=%b%b%b expected 110",
                     nm, k, o_bus_req, o_stall, o_done);
         end
         n_tests++;
         if ({o_bus_we, o_bus_addr, o_bus_be} !== {w, e_addr, e_be}) begin
            n_fail++;
            $display("FAIL %s bus%0d: we/addr/be=%b/%h/%b expected %b/%h/%b",
                     nm, k, o_bus_we, o_bus_addr, o_bus_be, w, e_addr, e_be);
         end
         if (st) begin
            n_tests++;
            if (o_bus_wdata !== e_wd) begin
               n_fail++;
               $display("FAIL %s wdata%0d: got %h expected %h", nm, k, o_bus_wdata, e_wd);
            end
         end
      end
      @(posedge clk); #1;
      ack = 1'b0; rdata = $urandom;
      @(negedge clk);
      n_tests++;
      if ({o_done, o_stall, o_bus_req, o_bus_err} !== {3'b100, to}) begin
         n_fail++;
         $display("FAIL %s done: done/stall/req/err=%b%b%b%b expected 100%b",
                  nm, o_done, o_stall, o_bus_req, o_bus_err, to);
      end
      n_tests++;
      if (o_ld_data !== e_ld) begin
         n_fail++;
         $display("FAIL %s ld_data: got %h expected %h", nm, o_ld_data, e_ld);
      end
      model_ld = e_ld;
      @(posedge clk); #1;
      re = 1'b0; we = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({o_done, o_bus_err, o_bus_req, o_stall} !== 4'b0000 || o_ld_data !== model_ld) begin
         n_fail++;
         $display("FAIL %s after: done/err/req/stall=%b%b%b%b ld=%h expected 0000 ld=%h",
                  nm, o_done, o_bus_err, o_bus_req, o_stall, o_ld_data, model_ld);
      end
   endtask

   task automatic test_reset();
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be, o_ld_data,
           o_done, o_bus_err, o_stall} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: req=%b we=%b addr=%h wd=%h be=%b ld=%h done=%b err=%b stall=%b expected all 0",
                  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be, o_ld_data,
                  o_done, o_bus_err, o_stall);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_store_byte();
      run_access("st_byte", 1'b0, 1'b1, SZ_BYTE, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0);
   endtask

   task automatic test_load_half();
      run_access("ld_half", 1'b1, 1'b0, SZ_HALF, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 2);
      n_tests++;
      if (dg_extend(DG_LH, o_ld_data) !== 32'hFFFF_BEEF) begin
         n_fail++;
         $display("FAIL dg_lh: got %h expected ffffbeef", dg_extend(DG_LH, o_ld_data));
      end
      n_tests++;
      if (dg_extend(DG_LHU, o_ld_data) !== 32'h0000_BEEF) begin
         n_fail++;
         $display("FAIL dg_lhu: got %h expected 0000beef", dg_extend(DG_LHU, o_ld_data));
      end
   endtask

   task automatic test_misalign(input string nm, input logic r, input logic w,
                                input logic [1:0] sz, input logic [31:0] a);
      @(posedge clk); #1;
      re = r; we = w; size = sz; addr = a; wdata = $urandom;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if ({o_misalign, o_stall, o_bus_req, o_done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s cyc%0d: mis/stall/req/done=%b%b%b%b expected 1000",
                     nm, k, o_misalign, o_stall, o_bus_req, o_done);
         end
         @(posedge clk); #1;
      end
      re = 1'b0; we = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({o_misalign, o_bus_req, o_done} !== 3'b000) begin
         n_fail++;
         $display("FAIL %s release: mis/req/done=%b%b%b expected 000",
                  nm, o_misalign, o_bus_req, o_done);
      end
   endtask

   task automatic test_timeout();
      run_access("timeout", 1'b1, 1'b0, SZ_WORD, 32'h0000_4000, 32'h0, 32'h1234_5678, 99);
      run_access("post_to", 1'b1, 1'b0, SZ_WORD, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 1);
      run_access("ack_at_last", 1'b1, 1'b0, SZ_BYTE, 32'h0000_4005, 32'h0, 32'h0011_2233, T - 1);
   endtask

   task automatic test_reset_mid_req();
      @(posedge clk); #1;
      re = 1'b1; we = 1'b0; size = SZ_WORD; addr = 32'h0000_0040; ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({o_bus_req, o_done, o_bus_err} !== 3'b000 || o_ld_data !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_mid: req/done/err=%b%b%b ld=%h expected 000 ld=0",
                  o_bus_req, o_done, o_bus_err, o_ld_data);
      end
      re = 1'b0; ack = 1'b1; rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      rst = 1'b0;
      model_ld = 32'd0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if ({o_bus_req, o_done, o_stall} !== 3'b000 || o_ld_data !== 32'd0) begin
            n_fail++;
            $display("FAIL late_ack%0d: req/done/stall=%b%b%b ld=%h expected 000 ld=0",
                     k, o_bus_req, o_done, o_stall, o_ld_data);
         end
         @(posedge clk); #1;
      end
      ack = 1'b0;
   endtask

   task automatic test_rw_both();
      run_access("re_we", 1'b1, 1'b1, SZ_WORD, 32'h0000_0010, 32'h5A5A_1234, 32'hFFFF_FFFF, 1);
   endtask

   task automatic test_random();
      logic        r, w;
      logic [1:0]  sz;
      logic [31:0] a;
      for (int i = 0; i < 40; i++) begin
         w  = 1'($urandom_range(0, 1));
         r  = w ? 1'($urandom_range(0, 1)) : 1'b1;
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if (sz == 2'd1) a[0] = 1'b0;
         else if (sz >= 2'd2) a[1:0] = 2'b00;
         run_access("rand", r, w, sz, a, $urandom, $urandom, int'($urandom_range(0, 4)));
      end
   endtask

   initial begin
      rst = 1'b1; re = 1'b0; we = 1'b0; ack = 1'b0;
      size = 2'b00; addr = 32'd0; wdata = 32'd0; rdata = 32'd0;
      test_reset();
      test_store_byte();
      test_load_half();
      test_misalign("mis_word", 1'b1, 1'b0, SZ_WORD, 32'h0000_3001);
      test_misalign("mis_half", 1'b0, 1'b1, SZ_HALF, 32'h0000_0013);
      test_misalign("mis_rsvd", 1'b1, 1'b0, 2'b11, 32'h0000_0082);
      test_timeout();
      test_reset_mid_req();
      test_rw_both();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Load/store bus controller feeding datagen (the load extend stage). Takes load and store requests from the single-cycle core and runs a req/ack transaction on the data-memory bus. It stalls the core until the transaction completes. Store data goes out with byte-lane replication and byte enables; load data comes back shifted right so the addressed byte or half lands in bits [7:0]/[15:0], ready for sign or zero extension downstream.

Parameters:
TIMEOUT_CYCLES, 16, maximum REQ cycles without i_bus_ack before the access is aborted with an error (legal range 2..255).

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_lsu_re  in  1  load request from the core, held stable while o_stall=1
i_lsu_we  in  1  store request from the core, held stable while o_stall=1
i_lsu_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
i_lsu_addr  in  32  byte address
i_lsu_wdata  in  32  store data, right-aligned
o_stall  out  1  core must hold PC and request
o_ld_data  out  32  right-aligned load word, sent to datagen i_wb_data
o_done  out  1  one-cycle pulse: access complete
o_misalign  out  1  combinational: current request is misaligned; no bus access is made
o_bus_err  out  1  valid with o_done: access timed out
o_bus_req  out  1  bus request (registered)
o_bus_we  out  1  bus write
o_bus_addr  out  32  word address, {i_lsu_addr[31:2],2'b00}
o_bus_wdata  out  32  lane-replicated store data
o_bus_be  out  4  byte enables (store only; 4'b0000 for loads)
i_bus_ack  in  1  bus completion, sampled only in REQ
i_bus_rdata  in  32  read word, valid with i_bus_ack

Behaviour:
- Reset: state IDLE. All registered outputs are 0: o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be, o_ld_data, o_done, o_bus_err. The timeout counter is 0.
- Reset mid-transaction: abort immediately. o_bus_req drops asynchronously, no o_done is produced, and the pending ack is dropped.
- State IDLE:
  - Accept when (re|we) and the request is aligned.
  - If re and we are both high, treat it as a store.
  - On accept: latch addr, size, we, lane data and be. o_stall=1 combinationally in this cycle. Next state REQ.
- Alignment:
  - half is misaligned when addr[0]=1.
  - word is misaligned when addr[1:0]!=0.
  - A misaligned request raises o_misalign, keeps o_stall=0, makes no state change and starts no bus activity.
- State REQ:
  - o_bus_req=1 and o_stall=1.
  - On i_bus_ack: capture the shifted rdata (loads only) and go to DONE.
  - Without ack: the counter increments. When counter == TIMEOUT_CYCLES-1 and still no ack, go to DONE with err=1 and o_ld_data=0.
  - An ack and the timeout in the same cycle resolve as ack, not error.
- State DONE:
  - One cycle. o_done=1, o_stall=0, o_bus_req=0, o_ld_data valid.
  - The core advances on this edge; next state is IDLE unconditionally.
  - Clear the counter; o_bus_err is cleared on leaving DONE.
- i_bus_ack outside REQ is ignored.
- Minimum latency: 3 cycles (IDLE accept, REQ with ack, DONE).
- Store lanes:
  - byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - half: wdata={2{d[15:0]}}, be=addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata=d, be=4'b1111.
- Load shift:
  - byte and half: o_ld_data = rdata >> (8*addr[1:0]). Upper bits are don't-care for datagen but must be the shifted value, not masked.
  - word: rdata unshifted.
- o_ld_data holds its value until the next load completes.

Decomposition:
- Package lsu_pkg holds:
  - the state enum (IDLE, REQ, DONE);
  - size constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - the datagen select codes (000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu), so decode drives both blocks consistently.
- One combinational sub-module, lsu_lane_align. It produces store replication, be and the load right-shift from addr[1:0] and size. The FSM and counter stay in lsu_bus_ctrl.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000AB, ack in the 1st REQ cycle -> o_bus_addr=0x1000, wdata=0xABABABAB, be=4'b1000, o_done in cycle 2, stall high in cycles 0-1.
- Load half: addr=0x2002, rdata=0xBEEF1234, ack after 3 REQ cycles -> o_ld_data=0x0000BEEF; datagen lh gives 0xFFFFBEEF, lhu gives 0x0000BEEF; stall for 4 cycles.
- Misaligned word load: addr=0x3001 -> o_misalign=1, o_stall=0, o_bus_req never asserted.
- Timeout: load with no ack, TIMEOUT_CYCLES=16 -> 16 REQ cycles, then o_done=1 with o_bus_err=1 and o_ld_data=0; next access completes with err=0.
- Reset mid-REQ: assert i_reset in the 2nd REQ cycle -> o_bus_req=0 immediately, no o_done; a late ack after reset is ignored.
- Simultaneous re & we: addr=0x10, size=word -> o_bus_we=1, be=4'b1111, treated as a store.
